cfu_simd_mac_pipe: RTL and testbench

- CFU-facing SIMD multiply-accumulate block. It is the parametrised successor of the single-core conv1d CFU wrapper.
- Accepts CPU custom-instruction commands and decodes an opcode from funct7 and an accumulator index from funct3.
- Executes packed signed MACs with a programmable input offset into NUM_ACC independent accumulators.
- Runs every command through an in-order LAT-stage pipeline and returns results through a RSP_DEPTH response FIFO, so back-to-back commands issue without waiting for each response hand-off.

---
 rtl/cfu_simd_mac_pipe.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_cfu_simd_mac_pipe.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_simd_mac_pipe.sv
// -----------------------------------------------------------------------------
// cfu_simd_mac_pipe
//
// Purpose:
//   Custom-function-unit SIMD multiply-accumulate engine. Each CPU command is
//   decoded into an opcode (funct7) and an accumulator index (funct3). MAC
//   commands add the sum of LANES packed signed lane products,
//   (sext(in0 lane) + offset) * sext(in1 lane), into one of NUM_ACC 32-bit
//   wrapping accumulators. Every command travels an in-order LAT-stage
//   pipeline and leaves its response in a RSP_DEPTH-entry FIFO.
//
//   Parameter constraints: LANES*LANE_W == 32, LANE_W < 9, NUM_ACC <= 8,
//   LAT >= 1, RSP_DEPTH >= LAT.
//
// Ports:
//   clk                       clock
//   reset                     asynchronous active-high reset; aborts in-flight
//                             commands, clears accumulators, offset and FIFO
//   cmd_valid / cmd_ready     command handshake
//   cmd_payload_function_id   [9:3] opcode, [2:0] accumulator index
//   cmd_payload_inputs_0      packed activations / SETOFF operand
//   cmd_payload_inputs_1      packed weights
//   rsp_valid / rsp_ready     response handshake (FIFO head)
//   rsp_payload_outputs_0     registered FIFO head data
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready are both high. The producer keeps valid and its
// payload stable until the transfer. cmd_ready never depends on cmd_valid,
// and rsp_valid never depends on rsp_ready, so no combinational loop can form.
// -----------------------------------------------------------------------------
module cfu_simd_mac_pipe #(
  parameter int LANES     = 4,
  parameter int LANE_W    = 8,
  parameter int NUM_ACC   = 4,
  parameter int LAT       = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int OFF_W  = 9;
  localparam int PROD_W = OFF_W + LANE_W;
  localparam int ACC_IW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  localparam logic [6:0] OP_CLR     = 7'd0;
  localparam logic [6:0] OP_SETOFF  = 7'd1;
  localparam logic [6:0] OP_MAC     = 7'd2;
  localparam logic [6:0] OP_READ    = 7'd3;
  localparam logic [6:0] OP_READCLR = 7'd4;

  // Operation kind carried down the pipe. Index range checking is folded into
  // the decode, so K_NONE covers both unknown opcodes and out-of-range idx.
  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_CLR   = 3'd1,
    K_OFF   = 3'd2,
    K_MAC   = 3'd3,
    K_READ  = 3'd4,
    K_RDCLR = 3'd5
  } kind_t;

  // ---------------------------------------------------------------------------
  // Accept stage: decode, offset update and lane products
  // ---------------------------------------------------------------------------
  logic                    accept;
  logic [6:0]              cmd_op;
  logic [2:0]              cmd_f3;
  logic                    idx_ok;
  kind_t                   acc_kind;
  logic [31:0]             acc_data;
  logic [31:0]             lane_sum;
  logic signed [OFF_W-1:0] offset_q;

  assign accept = cmd_valid && cmd_ready;
  assign cmd_op = cmd_payload_function_id[9:3];
  assign cmd_f3 = cmd_payload_function_id[2:0];
  assign idx_ok = ({29'd0, cmd_f3} < 32'(NUM_ACC));

  always_comb begin
    acc_kind = K_NONE;
    if (cmd_op == OP_SETOFF) begin
      acc_kind = K_OFF;
    end else if (idx_ok) begin
      case (cmd_op)
        OP_CLR:     acc_kind = K_CLR;
        OP_MAC:     acc_kind = K_MAC;
        OP_READ:    acc_kind = K_READ;
        OP_READCLR: acc_kind = K_RDCLR;
        default:    acc_kind = K_NONE;
      endcase
    end
  end

  // Lane arithmetic: the offset-adjusted activation is kept at 9 bits, so each
  // lane product is a 17-bit signed value, sign-extended into the 32-bit sum.
  always_comb begin
    logic signed [LANE_W-1:0] lane_a;
    logic signed [LANE_W-1:0] lane_b;
    logic signed [OFF_W-1:0]  adj_a;
    logic signed [PROD_W-1:0] prod;
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a   = cmd_payload_inputs_0[i*LANE_W +: LANE_W];
      lane_b   = cmd_payload_inputs_1[i*LANE_W +: LANE_W];
      adj_a    = OFF_W'(lane_a) + offset_q;
      prod     = PROD_W'(adj_a) * PROD_W'(lane_b);
      lane_sum = lane_sum + 32'(prod);
    end
  end

  // SETOFF carries the previous offset as its response; MAC carries the lane
  // sum. Everything else needs no payload.
  always_comb begin
    case (acc_kind)
      K_OFF:   acc_data = 32'(offset_q);
      K_MAC:   acc_data = lane_sum;
      default: acc_data = '0;
    endcase
  end

  // The offset commits at accept time, so the very next command (for example a
  // MAC issued back-to-back after SETOFF) already sees the new value when its
  // lane products are formed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset_q <= '0;
    end else if (accept && (cmd_op == OP_SETOFF)) begin
      offset_q <= signed'(cmd_payload_inputs_0[OFF_W-1:0]);
    end
  end

  // ---------------------------------------------------------------------------
  // In-order pipeline, LAT stages; stage LAT-1 is the accumulator/FIFO stage
  // ---------------------------------------------------------------------------
  logic [LAT-1:0]    vld_q;
  kind_t             kind_q [LAT];
  logic [ACC_IW-1:0] idx_q  [LAT];
  logic [31:0]       dat_q  [LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        kind_q[s] <= K_NONE;
        idx_q[s]  <= '0;
        dat_q[s]  <= '0;
      end
    end else begin
      vld_q[0]  <= accept;
      kind_q[0] <= acc_kind;
      idx_q[0]  <= cmd_f3[ACC_IW-1:0];
      dat_q[0]  <= acc_data;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s]  <= vld_q[s-1];
        kind_q[s] <= kind_q[s-1];
        idx_q[s]  <= idx_q[s-1];
        dat_q[s]  <= dat_q[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final stage: read-modify-write of the accumulator and FIFO push. Because
  // every access happens here in program order, dependent commands on the same
  // index need no forwarding.
  // ---------------------------------------------------------------------------
  logic              push;
  logic [31:0]       push_data;
  logic [ACC_IW-1:0] fin_idx;
  kind_t             fin_kind;
  logic [31:0]       fin_dat;
  logic [31:0]       acc_cur;
  logic [31:0]       acc_sum;
  logic              acc_we;
  logic [31:0]       acc_wval;
  logic [31:0]       acc_q [NUM_ACC];

  assign push     = vld_q[LAT-1];
  assign fin_idx  = idx_q[LAT-1];
  assign fin_kind = kind_q[LAT-1];
  assign fin_dat  = dat_q[LAT-1];
  assign acc_cur  = acc_q[fin_idx];
  assign acc_sum  = acc_cur + fin_dat;   // wraps modulo 2^32

  always_comb begin
    acc_we    = 1'b0;
    acc_wval  = '0;
    push_data = '0;
    case (fin_kind)
      K_CLR: begin
        acc_we = 1'b1;
      end
      K_OFF: begin
        push_data = fin_dat;
      end
      K_MAC: begin
        acc_we    = 1'b1;
        acc_wval  = acc_sum;
        push_data = acc_sum;
      end
      K_READ: begin
        push_data = acc_cur;
      end
      K_RDCLR: begin
        acc_we    = 1'b1;
        push_data = acc_cur;
      end
      default: begin
        push_data = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < NUM_ACC; a++) begin
        acc_q[a] <= '0;
      end
    end else if (push && acc_we) begin
      acc_q[fin_idx] <= acc_wval;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue control: a command is accepted only when a FIFO slot is reserved for
  // it, counting both stored responses and commands still in the pipe.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    inflight = '0;
    for (int s = 0; s < LAT; s++) begin
      inflight = inflight + CNT_W'(vld_q[s]);
    end
  end

  assign cmd_ready = (({1'b0, inflight} + {1'b0, count_q}) < (CNT_W+1)'(RSP_DEPTH));

  // ---------------------------------------------------------------------------
  // Response FIFO with a registered head
  // ---------------------------------------------------------------------------
  logic [31:0]      mem_q [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic             rsp_valid_q;
  logic             rsp_valid_d;
  logic [31:0]      head_q;
  logic [31:0]      head_d;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop = rsp_valid_q && rsp_ready;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    rsp_valid_d = (count_d != '0);
    // The next head is the entry at the next read pointer; if that slot is
    // being written in this same cycle, take the incoming data directly.
    head_d = '0;
    if (count_d != '0) begin
      head_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      head_q      <= head_d;
    end
  end

  // Storage needs no reset: an entry is only observable after it was pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = head_q;

endmodule

// File: tb/tb_cfu_simd_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_cfu_simd_mac_pipe
//
// Self-checking bench for cfu_simd_mac_pipe. Commands are driven through a
// driver task; each accepted command pushes its expected response into
// exp_q, and a response monitor pops and compares on every response transfer.
// Scenario tasks add their own inline checks for reset values, latency,
// throughput and backpressure behaviour.
// -----------------------------------------------------------------------------
module tb_cfu_simd_mac_pipe;

  localparam int LANES     = 4;
  localparam int LANE_W    = 8;
  localparam int NUM_ACC   = 4;
  localparam int LAT       = 2;
  localparam int RSP_DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  cfu_simd_mac_pipe #(
    .LANES     (LANES),
    .LANE_W    (LANE_W),
    .NUM_ACC   (NUM_ACC),
    .LAT       (LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  int unsigned cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [31:0]       exp_q[$];
  int                n_vec = 0;
  int                n_err = 0;
  int unsigned       last_acc_cyc = 0;
  logic [31:0]       m_acc [8];
  logic signed [8:0] m_off;

  function automatic logic [31:0] lane_sum_model(input logic signed [8:0] off,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
    int s;
    logic signed [7:0] x;
    logic signed [7:0] y;
    logic signed [8:0] ax;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      x  = a[8*i +: 8];
      y  = b[8*i +: 8];
      ax = 9'(x) + off;
      s  = s + int'(ax) * int'(y);
    end
    return 32'(s);
  endfunction

  function automatic logic [31:0] model_exec(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [31:0] in0, input logic [31:0] in1);
    logic [31:0] r;
    r = '0;
    if (f7 == 7'd1) begin
      r     = {{23{m_off[8]}}, m_off};
      m_off = in0[8:0];
    end else if (int'(f3) < NUM_ACC) begin
      case (f7)
        7'd0: begin m_acc[f3] = '0; r = '0; end
        7'd2: begin m_acc[f3] = m_acc[f3] + lane_sum_model(m_off, in0, in1); r = m_acc[f3]; end
        7'd3: r = m_acc[f3];
        7'd4: begin r = m_acc[f3]; m_acc[f3] = '0; end
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_acc[i] = '0;
    m_off = '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Response monitor: every response transfer is compared against exp_q
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset && rsp_valid && rsp_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: got %h, required no response", rsp_payload_outputs_0);
      end else begin
        e = exp_q.pop_front();
        if (rsp_payload_outputs_0 !== e) begin
          n_err++;
          $display("FAIL rsp_data: got %h, required %h", rsp_payload_outputs_0, e);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents a command and returns #1 after the accepting edge with cmd_valid
  // still high, so consecutive calls issue back-to-back.
  task automatic drive_cmd(input logic [6:0] f7, input logic [2:0] f3,
                           input logic [31:0] in0, input logic [31:0] in1,
                           input bit use_exp, input logic [31:0] exp_v);
    logic [31:0] pred;
    int w;
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {f7, f3};
    cmd_payload_inputs_0    = in0;
    cmd_payload_inputs_1    = in1;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b, required 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      pred = model_exec(f7, f3, in0, in1);
      exp_q.push_back(use_exp ? exp_v : pred);
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
    end
  endtask

  task automatic send(input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] in0, input logic [31:0] in1);
    drive_cmd(f7, f3, in0, in1, 1'b0, '0);
  endtask

  task automatic send_exp(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] in0, input logic [31:0] in1,
                          input logic [31:0] exp_v);
    drive_cmd(f7, f3, in0, in1, 1'b1, exp_v);
  endtask

  task automatic cmd_idle();
    cmd_valid               = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_%s: %0d responses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    cmd_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid);
    end
    n_vec++;
    if (rsp_payload_outputs_0 !== 32'h0) begin
      n_err++; $display("FAIL reset_rsp_data: got %h, required 00000000", rsp_payload_outputs_0);
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(7'd2, 3'd0, 32'h0000_0001, 32'h0000_0001);
    cmd_idle();
    @(posedge clk);
    #1;
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL midreset_pending: rsp_valid=%b, required 1", rsp_valid);
    end
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    #1;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_rsp_valid: got %b, required 0", rsp_valid);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL midreset_cmd_ready: got %b, required 1", cmd_ready);
    end
    rsp_ready = 1'b1;
    send_exp(7'd3, 3'd0, 32'h0, 32'h0, 32'h0);
    cmd_idle();
    drain("midreset");
  endtask

  task automatic test_basic_mac();
    rsp_ready = 1'b1;
    send_exp(7'd1, 3'd0, 32'd128, 32'h0, 32'h0);
    // (1+128)+(2+128)+(3+128)+(4+128) = 522
    send_exp(7'd2, 3'd1, 32'h0102_0304, 32'h0101_0101, 32'h0000_020A);
    send_exp(7'd3, 3'd1, 32'h0, 32'h0, 32'd522);
    cmd_idle();
    drain("basic");
  endtask

  task automatic test_signed_wrap();
    logic [31:0] rem;
    rsp_ready = 1'b1;
    send_exp(7'd1, 3'd0, 32'h0, 32'h0, 32'd128);
    // Four lanes of (-128 + 0) * 127 = -65024
    send_exp(7'd2, 3'd0, 32'h8080_8080, 32'h7F7F_7F7F, 32'hFFFF_0200);
    send_exp(7'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    // Climb idx0 to exactly 0x7FFFFFFF: coarse steps of 4*255*127, then fine.
    send(7'd1, 3'd0, 32'd128, 32'h0);
    rem = 32'h7FFF_FFFF - m_acc[0];
    while (rem >= 32'd129540) begin
      send(7'd2, 3'd0, 32'h7F7F_7F7F, 32'h7F7F_7F7F);
      rem = 32'h7FFF_FFFF - m_acc[0];
    end
    send(7'd1, 3'd0, 32'd0, 32'h0);
    while (rem >= 32'd508) begin
      send(7'd2, 3'd0, 32'h7F7F_7F7F, 32'h0101_0101);
      rem = 32'h7FFF_FFFF - m_acc[0];
    end
    while (rem != 32'd0) begin
      send(7'd2, 3'd0, (rem > 32'd127) ? 32'd127 : rem, 32'h0000_0001);
      rem = 32'h7FFF_FFFF - m_acc[0];
    end
    send_exp(7'd3, 3'd0, 32'h0, 32'h0, 32'h7FFF_FFFF);
    send_exp(7'd2, 3'd0, 32'h0000_0001, 32'h0000_0001, 32'h8000_0000);
    cmd_idle();
    drain("signed_wrap");
  endtask

  task automatic test_latency();
    rsp_ready = 1'b1;
    send(7'd3, 3'd3, 32'h0, 32'h0);
    cmd_idle();
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL latency_early: cycle +%0d rsp_valid=%b, required 0", k, rsp_valid);
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (rsp_valid !== 1'b1) begin
      n_err++; $display("FAIL latency_rise: cycle +%0d rsp_valid=%b, required 1", LAT, rsp_valid);
    end
    drain("latency");
  endtask

  task automatic test_back_to_back();
    int unsigned first_cyc;
    rsp_ready = 1'b1;
    send(7'd1, 3'd0, 32'd0, 32'h0);
    first_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      send_exp(7'd2, 3'd2, 32'h0000_0001, 32'h0000_0001, 32'(i + 1));
      if (i == 0) first_cyc = last_acc_cyc;
    end
    cmd_idle();
    n_vec++;
    if (last_acc_cyc - first_cyc != 32'd7) begin
      n_err++;
      $display("FAIL b2b_throughput: 8 accepts spanned %0d cycles, required 7", last_acc_cyc - first_cyc);
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    rsp_ready = 1'b0;
    for (int i = 0; i < RSP_DEPTH; i++) send(7'd2, 3'd1, 32'h0000_0001, 32'h0000_0001);
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_ready_drop: cmd_ready=%b, required 0", cmd_ready);
    end
    // Keep offering a command; it must not be accepted while the FIFO is full.
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {7'd3, 3'd1};
    repeat (LAT + 2) @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_full_state: cmd_ready=%b rsp_valid=%b, required 0/1", cmd_ready, rsp_valid);
    end
    held = exp_q[0];
    n_vec++;
    if (rsp_payload_outputs_0 !== held) begin
      n_err++; $display("FAIL bp_head: got %h, required %h", rsp_payload_outputs_0, held);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (rsp_payload_outputs_0 !== held || rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_hold: data %h valid %b, required %h 1", rsp_payload_outputs_0, rsp_valid, held);
    end
    cmd_idle();
    rsp_ready = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_edge_ops();
    rsp_ready = 1'b1;
    send_exp(7'd0, 3'd3, 32'h0, 32'h0, 32'h0);
    send(7'd1, 3'd0, 32'd0, 32'h0);
    send_exp(7'd2, 3'd3, 32'd55, 32'h0000_0001, 32'd55);
    send_exp(7'd4, 3'd3, 32'h0, 32'h0, 32'd55);
    send_exp(7'd3, 3'd3, 32'h0, 32'h0, 32'd0);
    send_exp(7'd2, 3'd5, 32'h0102_0304, 32'h0101_0101, 32'd0);
    send_exp(7'd9, 3'd1, 32'h0102_0304, 32'h0101_0101, 32'd0);
    send_exp(7'd3, 3'd1, 32'h0, 32'h0, m_acc[1]);
    // SETOFF immediately followed by MAC: the MAC must use the new offset (-1).
    send_exp(7'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    send_exp(7'd1, 3'd0, 32'h0000_01FF, 32'h0, 32'h0);
    // lane0 (3-1)*2 = 4, other lanes (0-1)*0 = 0
    send_exp(7'd2, 3'd0, 32'h0000_0003, 32'h0000_0002, 32'd4);
    send_exp(7'd1, 3'd7, 32'd5, 32'h0, 32'hFFFF_FFFF);
    send_exp(7'd1, 3'd0, 32'd0, 32'h0, 32'd5);
    cmd_idle();
    drain("edge");
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_reset_midstream();
    test_basic_mac();
    test_signed_wrap();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_edge_ops();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
